spi_slave_regbank: RTL and testbench

//  3-wire SPI responder with an internal 32x8 register bank; answers the frames issued by our SPI master.

---
 rtl/spi_slave_regbank.sv | 210 +++++++++++++++++++++
 tb/tb_spi_slave_regbank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regbank.sv
// spi_slave_regbank
// 3-wire SPI responder with a NREGS x 8 register bank and a second local
// read/write port. SPI pins are asynchronous to clk and are oversampled.
// A frame is SEN low, 16 SCLK rises, MSB first: header {RW, 2'b00, addr[4:0]}
// followed by 8 data bits. RW=0 writes the bank; RW=1 makes the slave drive
// the addressed byte on SDIO.
//
// Ports
//   clk, nrst         system clock, synchronous active-low reset
//   sclk, sen         SPI clock (idle low) and active-low frame enable
//   sdio_in           SDIO pad input
//   sdio_out/sdio_oe  SDIO pad output value / output enable (1 = slave drives)
//   loc_addr/loc_we/loc_wdata  local write port
//   loc_rdata         local read data, 1-clk latency from loc_addr
//   spi_wr            1-clk pulse after an SPI write commits
//   spi_addr          address of the last accepted SPI header
//   loc_collide       1-clk pulse when loc_we lost to an SPI commit
//   frame_err         1-clk pulse on bad header bits or SEN rising mid-frame
//   busy              frame in progress
module spi_slave_regbank #(
    parameter int          SYNC_STAGES = 2,
    parameter int          NREGS       = 32,
    parameter logic [7:0]  RST_VAL     = 8'h00
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       sclk,
    input  logic       sen,
    input  logic       sdio_in,
    output logic       sdio_out,
    output logic       sdio_oe,
    input  logic [4:0] loc_addr,
    input  logic       loc_we,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    output logic       spi_wr,
    output logic [4:0] spi_addr,
    output logic       loc_collide,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, HDR, WDATA, RDATA, WAIT_END} state_t;

    state_t                 state_r, next_state_s;
    logic [SYNC_STAGES-1:0] sclk_sync_r, sen_sync_r, sdio_sync_r;
    logic [3:0]             bit_ctr_r;
    logic [6:0]             shift_r;
    logic [7:0]             rd_shift_r;
    logic [7:0]             bank_r [NREGS];

    logic       sclk_rise_s, sclk_fall_s, sen_rise_s, sen_fall_s, sdio_s;
    logic [7:0] frame_byte_s;
    logic       hdr_done_s, hdr_bad_s, commit_s, abort_s;

    function automatic logic in_range(input logic [4:0] a);
        return (int'(a) < NREGS);
    endfunction

    function automatic logic [7:0] rd_bank(input logic [4:0] a);
        return in_range(a) ? bank_r[a] : 8'h00;
    endfunction

    // Edges come from the two oldest synchronizer stages; data uses the oldest.
    assign sclk_rise_s  =  sclk_sync_r[SYNC_STAGES-2] & ~sclk_sync_r[SYNC_STAGES-1];
    assign sclk_fall_s  = ~sclk_sync_r[SYNC_STAGES-2] &  sclk_sync_r[SYNC_STAGES-1];
    assign sen_rise_s   =  sen_sync_r[SYNC_STAGES-2]  & ~sen_sync_r[SYNC_STAGES-1];
    assign sen_fall_s   = ~sen_sync_r[SYNC_STAGES-2]  &  sen_sync_r[SYNC_STAGES-1];
    assign sdio_s       = sdio_sync_r[SYNC_STAGES-1];
    assign frame_byte_s = {shift_r, sdio_s};
    assign busy         = (state_r != IDLE);

    // Pin synchronizers. SEN resets low so that a reset released while the
    // master still holds SEN low does not look like a new frame start.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sclk_sync_r <= '0;
            sen_sync_r  <= '0;
            sdio_sync_r <= '0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            sen_sync_r  <= {sen_sync_r[SYNC_STAGES-2:0], sen};
            sdio_sync_r <= {sdio_sync_r[SYNC_STAGES-2:0], sdio_in};
        end
    end

    // Next-state and frame event decode; SEN rise overrides any SCLK edge.
    always_comb begin
        next_state_s = state_r;
        hdr_done_s   = 1'b0;
        hdr_bad_s    = (frame_byte_s[6:5] != 2'b00);
        commit_s     = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (sen_fall_s) next_state_s = HDR;
                else            next_state_s = IDLE;
            end
            HDR: begin
                if (sen_rise_s) begin
                    abort_s      = 1'b1;
                    next_state_s = IDLE;
                end else if (sclk_rise_s && bit_ctr_r == 4'd7) begin
                    hdr_done_s = 1'b1;
                    if (hdr_bad_s)            next_state_s = WAIT_END;
                    else if (frame_byte_s[7]) next_state_s = RDATA;
                    else                      next_state_s = WDATA;
                end else begin
                    next_state_s = HDR;
                end
            end
            WDATA: begin
                if (sen_rise_s) begin
                    abort_s      = 1'b1;
                    next_state_s = IDLE;
                end else if (sclk_rise_s && bit_ctr_r == 4'd15) begin
                    commit_s     = 1'b1;
                    next_state_s = WAIT_END;
                end else begin
                    next_state_s = WDATA;
                end
            end
            RDATA: begin
                // Counter wraps to 0 on the 16th rise; the following fall ends
                // the drive window.
                if (sen_rise_s) begin
                    abort_s      = 1'b1;
                    next_state_s = IDLE;
                end else if (sclk_fall_s && bit_ctr_r == 4'd0) begin
                    next_state_s = WAIT_END;
                end else begin
                    next_state_s = RDATA;
                end
            end
            WAIT_END: begin
                if (sen_rise_s) next_state_s = IDLE;
                else            next_state_s = WAIT_END;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Bit counter and receive shifter, cleared between frames.
    always_ff @(posedge clk) begin
        if (!nrst || state_r == IDLE) begin
            bit_ctr_r <= 4'd0;
            shift_r   <= 7'd0;
        end else if (sclk_rise_s && !sen_rise_s &&
                     (state_r == HDR || state_r == WDATA || state_r == RDATA)) begin
            bit_ctr_r <= bit_ctr_r + 4'd1;
            shift_r   <= frame_byte_s[6:0];
        end
    end

    // Status pulses, address latch and SDIO drive; read byte is snapshotted
    // at header completion so later local writes cannot disturb it.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            spi_wr      <= 1'b0;
            frame_err   <= 1'b0;
            loc_collide <= 1'b0;
            spi_addr    <= 5'd0;
            rd_shift_r  <= 8'h00;
            sdio_oe     <= 1'b0;
            sdio_out    <= 1'b1;
        end else begin
            spi_wr      <= commit_s;
            frame_err   <= abort_s | (hdr_done_s & hdr_bad_s);
            loc_collide <= commit_s & loc_we;
            if (hdr_done_s && !hdr_bad_s) begin
                spi_addr   <= frame_byte_s[4:0];
                rd_shift_r <= rd_bank(frame_byte_s[4:0]);
            end
            if (state_r == RDATA && next_state_s == RDATA) begin
                if (sclk_fall_s) begin
                    sdio_oe    <= 1'b1;
                    sdio_out   <= rd_shift_r[7];
                    rd_shift_r <= {rd_shift_r[6:0], 1'b0};
                end
            end else begin
                sdio_oe  <= 1'b0;
                sdio_out <= 1'b1;
            end
        end
    end

    // Register bank; an SPI commit takes the write port ahead of loc_we.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < NREGS; i++) bank_r[i] <= RST_VAL;
        end else if (commit_s) begin
            if (in_range(spi_addr)) bank_r[spi_addr] <= frame_byte_s;
        end else if (loc_we) begin
            if (in_range(loc_addr)) bank_r[loc_addr] <= loc_wdata;
        end
    end

    // Local read port.
    always_ff @(posedge clk) begin
        if (!nrst) loc_rdata <= 8'h00;
        else       loc_rdata <= rd_bank(loc_addr);
    end

endmodule

// File: tb/tb_spi_slave_regbank.sv
module tb_spi_slave_regbank;

    localparam int H = 6;   // SCLK half period in clk cycles

    logic       clk = 1'b0, nrst = 1'b0;
    logic       sclk = 1'b0, sen = 1'b1, sdio_in = 1'b1;
    logic [4:0] loc_addr = 5'd0;
    logic       loc_we = 1'b0;
    logic [7:0] loc_wdata = 8'h00;
    logic       sdio_out, sdio_oe, spi_wr, loc_collide, frame_err, busy;
    logic [7:0] loc_rdata;
    logic [4:0] spi_addr;

    spi_slave_regbank dut (
        .clk(clk), .nrst(nrst), .sclk(sclk), .sen(sen), .sdio_in(sdio_in),
        .sdio_out(sdio_out), .sdio_oe(sdio_oe), .loc_addr(loc_addr),
        .loc_we(loc_we), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
        .spi_wr(spi_wr), .spi_addr(spi_addr), .loc_collide(loc_collide),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int err_cnt = 0, wr_cnt = 0, col_cnt = 0;
    logic [7:0] model [32];
    logic [4:0] model_spi_addr = 5'd0;

    always @(posedge clk) begin
        if (frame_err)   err_cnt++;
        if (spi_wr)      wr_cnt++;
        if (loc_collide) col_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input logic col, output logic oe, output logic so);
        sdio_in = b;
        wait_clk(H);
        oe   = sdio_oe;
        so   = sdio_out;
        sclk = 1'b1;
        if (col) begin
            wait_clk(1);
            loc_addr  = 5'd9;
            loc_wdata = 8'hEE;
            loc_we    = 1'b1;
            wait_clk(1);
            loc_we    = 1'b0;
            wait_clk(H - 2);
        end else begin
            wait_clk(H);
        end
        sclk = 1'b0;
    endtask

    task automatic spi_xfer(input logic [7:0] hdr, input logic [7:0] din, input int nbits,
                            input logic col, output logic [7:0] dout, output logic [15:0] oe_seen);
        logic b, o, s;
        dout    = 8'h00;
        oe_seen = 16'h0000;
        sen     = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nbits; i++) begin
            if (i < 8) b = hdr[7-i];
            else       b = din[15-i];
            drive_bit(b, col && (i == nbits - 1), o, s);
            oe_seen[i] = o;
            if (i >= 8) dout[15-i] = s;
        end
        wait_clk(H);
        if (nbits == 16) check("oe_after_last_fall", sdio_oe, 1'b0);
        sen = 1'b1;
        wait_clk(2 * H);
        sdio_in = 1'b1;
        check("oe_after_sen", sdio_oe, 1'b0);
        check("busy_after_sen", busy, 1'b0);
    endtask

    task automatic loc_wr(input logic [4:0] a, input logic [7:0] d);
        loc_addr  = a;
        loc_wdata = d;
        loc_we    = 1'b1;
        wait_clk(1);
        loc_we    = 1'b0;
    endtask

    task automatic loc_rd(input logic [4:0] a, output logic [7:0] d);
        loc_addr = a;
        wait_clk(1);
        d = loc_rdata;
    endtask

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] din;
        logic [7:0] exp_rd;
        logic       exp_err;
        logic       exp_wr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [7:0]  rd, dout;
        logic [15:0] oe_seen, oe_exp;
        int          e0, w0, c0, nbits;
        logic [4:0]  a;
        logic [7:0]  d, din, hdr;
        logic        rw, bad;
        logic [1:0]  mid;

        tbl[0] = '{8'h05, 8'hA5, 8'h00, 1'b0, 1'b1};
        tbl[1] = '{8'h85, 8'h00, 8'hA5, 1'b0, 1'b0};
        tbl[2] = '{8'h45, 8'hFF, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h85, 8'h00, 8'hA5, 1'b0, 1'b0};
        tbl[4] = '{8'h1F, 8'h5A, 8'h00, 1'b0, 1'b1};
        tbl[5] = '{8'h9F, 8'h00, 8'h5A, 1'b0, 1'b0};
        tbl[6] = '{8'h25, 8'h11, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{8'h80, 8'h00, 8'h00, 1'b0, 1'b0};
        for (int i = 0; i < 32; i++) model[i] = 8'h00;

        // Reset state
        wait_clk(3);
        check("rst_sdio_out", sdio_out, 1'b1);
        check("rst_sdio_oe", sdio_oe, 1'b0);
        check("rst_loc_rdata", loc_rdata, 8'h00);
        check("rst_spi_wr", spi_wr, 1'b0);
        check("rst_spi_addr", spi_addr, 5'd0);
        check("rst_loc_collide", loc_collide, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        nrst = 1'b1;
        wait_clk(2 * H);

        // Table-driven frames
        for (int t = 0; t < 8; t++) begin
            e0 = err_cnt; w0 = wr_cnt;
            spi_xfer(tbl[t].hdr, tbl[t].din, 16, 1'b0, dout, oe_seen);
            if (tbl[t].exp_wr) model[tbl[t].hdr[4:0]] = tbl[t].din;
            if (!tbl[t].exp_err) model_spi_addr = tbl[t].hdr[4:0];
            oe_exp = (tbl[t].hdr[7] && !tbl[t].exp_err) ? 16'hFF00 : 16'h0000;
            check($sformatf("tbl%0d_err", t), err_cnt - e0, {31'd0, tbl[t].exp_err});
            check($sformatf("tbl%0d_wr", t), wr_cnt - w0, {31'd0, tbl[t].exp_wr});
            check($sformatf("tbl%0d_oe", t), oe_seen, oe_exp);
            check($sformatf("tbl%0d_spi_addr", t), spi_addr, model_spi_addr);
            if (tbl[t].hdr[7] && !tbl[t].exp_err)
                check($sformatf("tbl%0d_rd", t), dout, tbl[t].exp_rd);
        end
        loc_rd(5'd5, rd);  check("loc_rd5", rd, 8'hA5);
        loc_rd(5'd31, rd); check("loc_rd31", rd, 8'h5A);

        // Local write then SPI read of addr 3
        loc_wr(5'd3, 8'h3C); model[3] = 8'h3C;
        spi_xfer(8'h83, 8'h00, 16, 1'b0, dout, oe_seen);
        check("rd3_data", dout, 8'h3C);
        check("rd3_oe", oe_seen, 16'hFF00);

        // SEN rises after 4 data bits of a write to addr 7
        e0 = err_cnt; w0 = wr_cnt;
        spi_xfer(8'h07, 8'hFF, 12, 1'b0, dout, oe_seen);
        model_spi_addr = 5'd7;
        check("abort_err", err_cnt - e0, 1);
        check("abort_wr", wr_cnt - w0, 0);
        loc_rd(5'd7, rd); check("abort_bank7", rd, model[7]);

        // SPI commit to addr 2 coincident with loc_we to addr 9
        e0 = err_cnt; w0 = wr_cnt; c0 = col_cnt;
        spi_xfer(8'h02, 8'h77, 16, 1'b1, dout, oe_seen);
        model[2] = 8'h77; model_spi_addr = 5'd2;
        check("col_pulse", col_cnt - c0, 1);
        check("col_wr", wr_cnt - w0, 1);
        loc_rd(5'd2, rd); check("col_bank2", rd, 8'h77);
        loc_rd(5'd9, rd); check("col_bank9", rd, model[9]);

        // Randomised frames against the model
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = 5'($urandom_range(0, 31)); d = 8'($urandom);
                loc_wr(a, d); model[a] = d;
            end
            a     = 5'($urandom_range(0, 31));
            rw    = 1'($urandom_range(0, 1));
            bad   = ($urandom_range(0, 5) == 0);
            mid   = bad ? 2'($urandom_range(1, 3)) : 2'b00;
            hdr   = {rw, mid, a};
            din   = 8'($urandom);
            nbits = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : 16;
            oe_exp = 16'h0000;
            for (int i = 8; i < nbits; i++) oe_exp[i] = rw & ~bad;
            e0 = err_cnt; w0 = wr_cnt;
            spi_xfer(hdr, din, nbits, 1'b0, dout, oe_seen);
            if (!bad) model_spi_addr = a;
            check("rnd_err", err_cnt - e0, (bad || nbits < 16) ? 1 : 0);
            check("rnd_wr", wr_cnt - w0, (!bad && !rw && nbits == 16) ? 1 : 0);
            check("rnd_oe", oe_seen, oe_exp);
            check("rnd_spi_addr", spi_addr, model_spi_addr);
            if (!bad && rw && nbits == 16) check("rnd_rd", dout, model[a]);
            if (!bad && !rw && nbits == 16) model[a] = din;
            loc_rd(a, rd); check("rnd_bank", rd, model[a]);
        end

        // Reset in the middle of a read of addr 3
        sen = 1'b0;
        wait_clk(H);
        for (int i = 0; i < 10; i++) begin
            logic o, s;
            drive_bit((i < 8) ? hdr_bit(8'h83, i) : 1'b0, 1'b0, o, s);
        end
        wait_clk(H);
        check("pre_rst_oe", sdio_oe, 1'b1);
        nrst = 1'b0;
        wait_clk(1);
        check("midrst_oe", sdio_oe, 1'b0);
        check("midrst_busy", busy, 1'b0);
        sen = 1'b1;
        wait_clk(4);
        nrst = 1'b1;
        wait_clk(2 * H);
        check("postrst_busy", busy, 1'b0);
        for (int i = 0; i < 32; i++) begin
            loc_rd(5'(i), rd);
            check($sformatf("postrst_bank%0d", i), rd, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic hdr_bit(input logic [7:0] h, input int i);
        return h[7-i];
    endfunction

endmodule
